// File: rtl/shunt_fringe.sv
// Fringe-link endpoint: a table of signal slots exchanged with a remote partition
// as {type, idx, payload} frames, gated by a post-reset registration handshake.
module shunt_fringe #(
   parameter int N_SIGNALS    = 10,
   parameter int PAYLOAD_W    = 9,
   parameter int IDX_W        = 4,
   parameter int IS_INITIATOR = 1,
   parameter int FRAME_W      = 2 + IDX_W + PAYLOAD_W
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 put_req_i,
   input  logic [IDX_W-1:0]     put_idx_i,
   input  logic [PAYLOAD_W-1:0] put_data_i,
   output logic                 put_ack_o,
   input  logic [IDX_W-1:0]     get_idx_i,
   output logic [PAYLOAD_W-1:0] get_data_o,
   output logic                 get_valid_o,
   input  logic                 get_clr_i,
   output logic                 tx_valid_o,
   input  logic                 tx_ready_i,
   output logic [FRAME_W-1:0]   tx_data_o,
   input  logic                 rx_valid_i,
   output logic                 rx_ready_o,
   input  logic [FRAME_W-1:0]   rx_data_i,
   output logic                 reg_done_o,
   output logic                 err_o,
   output logic                 overrun_o
);

   localparam logic [1:0]       T_DATA   = 2'b00;
   localparam logic [1:0]       T_REG    = 2'b01;
   localparam logic [1:0]       T_ACK    = 2'b10;
   localparam logic [1:0]       T_BAD    = 2'b11;
   localparam logic [IDX_W:0]   N_LIM    = (IDX_W+1)'(N_SIGNALS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SIGNALS - 1);

   typedef enum logic [1:0] {ST_SEND, ST_WAIT, ST_READY} state_t;

   state_t                 state_r, state_s;
   logic [IDX_W-1:0]       reg_idx_r, reg_idx_s;
   logic [PAYLOAD_W-1:0]   payload_db_r [N_SIGNALS];
   logic [N_SIGNALS-1:0]   valid_r;
   logic                   tx_valid_r, tx_last_r, rx_ready_r, reg_done_r, err_r, overrun_r;
   logic [FRAME_W-1:0]     tx_data_r, reg_frame_s;
   logic                   pend_r;
   logic [IDX_W-1:0]       pend_idx_r;
   logic                   reg_load_s, ack_err_s, last_load_s;

   logic [1:0]             rx_type_s;
   logic [IDX_W-1:0]       rx_idx_s;
   logic [PAYLOAD_W-1:0]   rx_pay_s;
   logic                   rx_fire_s, rx_in_range_s, rx_wr_s, rx_err_s, rx_reg_s, ovr_hit_s;
   logic                   tx_fire_s, tx_free_s;
   logic                   put_in_range_s, put_ok_s, put_err_s, get_in_range_s;

   assign rx_type_s      = rx_data_i[FRAME_W-1 -: 2];
   assign rx_idx_s       = rx_data_i[PAYLOAD_W +: IDX_W];
   assign rx_pay_s       = rx_data_i[PAYLOAD_W-1:0];
   assign rx_fire_s      = rx_valid_i & rx_ready_r;
   assign rx_in_range_s  = ({1'b0, rx_idx_s} < N_LIM);
   assign put_in_range_s = ({1'b0, put_idx_i} < N_LIM);
   assign get_in_range_s = ({1'b0, get_idx_i} < N_LIM);

   assign tx_fire_s = tx_valid_r & tx_ready_i;
   assign tx_free_s = ~tx_valid_r | tx_fire_s;

   assign rx_wr_s   = rx_fire_s & (rx_type_s == T_DATA) & reg_done_r & rx_in_range_s;
   assign rx_err_s  = rx_fire_s & (((rx_type_s == T_DATA) & ~(reg_done_r & rx_in_range_s)) |
                                   (rx_type_s == T_BAD));
   assign rx_reg_s  = rx_fire_s & (rx_type_s == T_REG) & (IS_INITIATOR == 0) & ~reg_done_r;
   // A same-cycle clear of the slot being written means the old value was consumed
   assign ovr_hit_s = rx_wr_s & valid_r[rx_idx_s] & ~(get_clr_i & (get_idx_i == rx_idx_s));

   // Registration frames take priority over puts for the shared TX register
   assign put_ok_s  = put_req_i & reg_done_r & put_in_range_s & tx_free_s & ~reg_load_s;
   assign put_err_s = put_req_i & ~(reg_done_r & put_in_range_s);
   assign put_ack_o = put_ok_s;

   assign tx_valid_o = tx_valid_r;
   assign tx_data_o  = tx_data_r;
   assign rx_ready_o = rx_ready_r;
   assign reg_done_o = reg_done_r;
   assign err_o      = err_r;
   assign overrun_o  = overrun_r;

   // Registration next-state: initiator walks the slot list, target echoes pending REGs
   always_comb begin
      state_s     = state_r;
      reg_idx_s   = reg_idx_r;
      reg_load_s  = 1'b0;
      reg_frame_s = {FRAME_W{1'b0}};
      ack_err_s   = 1'b0;
      last_load_s = 1'b0;
      if (IS_INITIATOR != 0) begin
         case (state_r)
            ST_SEND: begin
               if (tx_free_s) begin
                  reg_load_s  = 1'b1;
                  reg_frame_s = {T_REG, reg_idx_r, {PAYLOAD_W{1'b0}}};
                  state_s     = ST_WAIT;
               end else begin
                  state_s = ST_SEND;
               end
            end
            ST_WAIT: begin
               if (rx_fire_s && (rx_type_s == T_ACK)) begin
                  if (rx_idx_s != reg_idx_r) begin
                     ack_err_s = 1'b1;
                  end else if (reg_idx_r == LAST_IDX) begin
                     state_s = ST_READY;
                  end else begin
                     reg_idx_s = reg_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                     state_s   = ST_SEND;
                  end
               end else begin
                  state_s = ST_WAIT;
               end
            end
            ST_READY: state_s = ST_READY;
            default: begin
               state_s   = ST_SEND;
               reg_idx_s = {IDX_W{1'b0}};
            end
         endcase
      end else begin
         if (pend_r && tx_free_s) begin
            reg_load_s  = 1'b1;
            reg_frame_s = {T_ACK, pend_idx_r, {PAYLOAD_W{1'b0}}};
            last_load_s = (pend_idx_r == LAST_IDX);
         end else begin
            reg_load_s = 1'b0;
         end
      end
   end

   // Control state: FSM, TX register, pending target ack and status flags
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r    <= ST_SEND;
         reg_idx_r  <= {IDX_W{1'b0}};
         tx_valid_r <= 1'b0;
         tx_data_r  <= {FRAME_W{1'b0}};
         tx_last_r  <= 1'b0;
         pend_r     <= 1'b0;
         pend_idx_r <= {IDX_W{1'b0}};
         rx_ready_r <= 1'b0;
         reg_done_r <= 1'b0;
         err_r      <= 1'b0;
         overrun_r  <= 1'b0;
      end else begin
         state_r    <= state_s;
         reg_idx_r  <= reg_idx_s;
         rx_ready_r <= 1'b1;
         err_r      <= put_err_s | rx_err_s | ack_err_s;
         overrun_r  <= overrun_r | ovr_hit_s;
         if (reg_load_s) begin
            tx_valid_r <= 1'b1;
            tx_data_r  <= reg_frame_s;
            tx_last_r  <= last_load_s;
         end else if (put_ok_s) begin
            tx_valid_r <= 1'b1;
            tx_data_r  <= {T_DATA, put_idx_i, put_data_i};
            tx_last_r  <= 1'b0;
         end else if (tx_fire_s) begin
            tx_valid_r <= 1'b0;
            tx_last_r  <= 1'b0;
         end else begin
            tx_valid_r <= tx_valid_r;
         end
         if (rx_reg_s) begin
            pend_r     <= 1'b1;
            pend_idx_r <= rx_idx_s;
         end else if (reg_load_s) begin
            pend_r <= 1'b0;
         end else begin
            pend_r <= pend_r;
         end
         if (IS_INITIATOR != 0) begin
            reg_done_r <= (state_s == ST_READY);
         end else begin
            reg_done_r <= reg_done_r | (tx_fire_s & tx_last_r);
         end
      end
   end

   // Slot table: a write in the same cycle as a clear of that slot leaves it valid
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_r <= {N_SIGNALS{1'b0}};
         for (int i = 0; i < N_SIGNALS; i++) begin
            payload_db_r[i] <= {PAYLOAD_W{1'b0}};
         end
      end else begin
         if (get_clr_i && get_in_range_s) begin
            valid_r[get_idx_i] <= 1'b0;
         end else begin
            valid_r <= valid_r;
         end
         if (rx_wr_s) begin
            payload_db_r[rx_idx_s] <= rx_pay_s;
            valid_r[rx_idx_s]      <= 1'b1;
         end else begin
            valid_r[0] <= valid_r[0] & ~(get_clr_i && (get_idx_i == {IDX_W{1'b0}}));
         end
      end
   end

   // Combinational slot read
   always_comb begin
      get_data_o  = {PAYLOAD_W{1'b0}};
      get_valid_o = 1'b0;
      if (get_in_range_s) begin
         get_data_o  = payload_db_r[get_idx_i];
         get_valid_o = valid_r[get_idx_i];
      end else begin
         get_data_o  = {PAYLOAD_W{1'b0}};
         get_valid_o = 1'b0;
      end
   end

endmodule

// File: tb/tb_shunt_fringe.sv
// Directed bench for shunt_fringe: registration, a table of put/RX/get vectors,
// TX back-pressure and reset in the middle of traffic.
module tb_shunt_fringe;

   localparam int FW = 15;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          put_req_i, get_clr_i, tx_ready_i, rx_valid_i;
   logic [3:0]    put_idx_i, get_idx_i;
   logic [8:0]    put_data_i;
   logic [FW-1:0] rx_data_i;
   logic          put_ack_o, get_valid_o, tx_valid_o, rx_ready_o, reg_done_o, err_o, overrun_o;
   logic [8:0]    get_data_o;
   logic [FW-1:0] tx_data_o;

   int checks = 0;
   int errors = 0;

   shunt_fringe dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .put_req_i(put_req_i), .put_idx_i(put_idx_i), .put_data_i(put_data_i), .put_ack_o(put_ack_o),
      .get_idx_i(get_idx_i), .get_data_o(get_data_o), .get_valid_o(get_valid_o), .get_clr_i(get_clr_i),
      .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i), .tx_data_o(tx_data_o),
      .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o), .rx_data_i(rx_data_i),
      .reg_done_o(reg_done_o), .err_o(err_o), .overrun_o(overrun_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic          put_req;
      logic [3:0]    put_idx;
      logic [8:0]    put_data;
      logic          rx_valid;
      logic [FW-1:0] rx_data;
      logic [3:0]    get_idx;
      logic          get_clr;
      logic          exp_ack;
      logic          exp_txv;
      logic [FW-1:0] exp_tx;
      logic          exp_err;
      logic          exp_gv;
      logic [8:0]    exp_gd;
      logic          exp_ovr;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic pr, input logic [3:0] pi, input logic [8:0] pd,
                               input logic rv, input logic [FW-1:0] rd,
                               input logic [3:0] gi, input logic gc,
                               input logic ea, input logic etv, input logic [FW-1:0] et,
                               input logic ee, input logic egv, input logic [8:0] egd, input logic eo);
      vec_t v;
      v.put_req = pr; v.put_idx = pi; v.put_data = pd;
      v.rx_valid = rv; v.rx_data = rd; v.get_idx = gi; v.get_clr = gc;
      v.exp_ack = ea; v.exp_txv = etv; v.exp_tx = et; v.exp_err = ee;
      v.exp_gv = egv; v.exp_gd = egd; v.exp_ovr = eo;
      return v;
   endfunction

   initial begin
      int        n_reg;
      logic      ack_pend;
      logic [3:0] ack_idx;
      logic [FW-1:0] f1, f2;

      //            put  idx    data     rx   rx frame                     get    clr   ack  txv  tx frame                     err  gv   gd      ovr
      vecs[0]  = mk(1'b1, 4'd0, 9'h1A5, 1'b0, {FW{1'b0}},                  4'd3, 1'b0, 1'b1, 1'b1, {2'b00, 4'd0, 9'h1A5},     1'b0, 1'b0, 9'h000, 1'b0);
      vecs[1]  = mk(1'b0, 4'd0, 9'h000, 1'b1, {2'b00, 4'd3, 9'h0FF},       4'd3, 1'b0, 1'b0, 1'b0, {FW{1'b0}},                1'b0, 1'b1, 9'h0FF, 1'b0);
      vecs[2]  = mk(1'b0, 4'd0, 9'h000, 1'b0, {FW{1'b0}},                  4'd3, 1'b1, 1'b0, 1'b0, {FW{1'b0}},                1'b0, 1'b0, 9'h0FF, 1'b0);
      vecs[3]  = mk(1'b0, 4'd0, 9'h000, 1'b1, {2'b00, 4'd3, 9'h011},       4'd3, 1'b0, 1'b0, 1'b0, {FW{1'b0}},                1'b0, 1'b1, 9'h011, 1'b0);
      vecs[4]  = mk(1'b0, 4'd0, 9'h000, 1'b1, {2'b00, 4'd3, 9'h033},       4'd3, 1'b1, 1'b0, 1'b0, {FW{1'b0}},                1'b0, 1'b1, 9'h033, 1'b0);
      vecs[5]  = mk(1'b0, 4'd0, 9'h000, 1'b1, {2'b00, 4'd3, 9'h044},       4'd3, 1'b0, 1'b0, 1'b0, {FW{1'b0}},                1'b0, 1'b1, 9'h044, 1'b1);
      vecs[6]  = mk(1'b0, 4'd0, 9'h000, 1'b0, {FW{1'b0}},                  4'd3, 1'b0, 1'b0, 1'b0, {FW{1'b0}},                1'b0, 1'b1, 9'h044, 1'b1);
      vecs[7]  = mk(1'b1, 4'd12, 9'h001, 1'b0, {FW{1'b0}},                 4'd3, 1'b0, 1'b0, 1'b0, {FW{1'b0}},                1'b1, 1'b1, 9'h044, 1'b1);
      vecs[8]  = mk(1'b0, 4'd0, 9'h000, 1'b1, {2'b00, 4'd15, 9'h1FF},      4'd3, 1'b0, 1'b0, 1'b0, {FW{1'b0}},                1'b1, 1'b1, 9'h044, 1'b1);
      vecs[9]  = mk(1'b0, 4'd0, 9'h000, 1'b1, {2'b11, 4'd2, 9'h0AA},       4'd2, 1'b0, 1'b0, 1'b0, {FW{1'b0}},                1'b1, 1'b0, 9'h000, 1'b1);
      vecs[10] = mk(1'b1, 4'd9, 9'h0AA, 1'b1, {2'b00, 4'd9, 9'h077},       4'd9, 1'b0, 1'b1, 1'b1, {2'b00, 4'd9, 9'h0AA},     1'b0, 1'b1, 9'h077, 1'b1);
      vecs[11] = mk(1'b0, 4'd0, 9'h000, 1'b0, {FW{1'b0}},                  4'd9, 1'b0, 1'b0, 1'b0, {FW{1'b0}},                1'b0, 1'b1, 9'h077, 1'b1);

      rst_ni = 1'b0; put_req_i = 1'b0; put_idx_i = 4'd0; put_data_i = 9'h000;
      get_idx_i = 4'd3; get_clr_i = 1'b0; tx_ready_i = 1'b1; rx_valid_i = 1'b0; rx_data_i = {FW{1'b0}};

      // Reset state
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_tx_valid", tx_valid_o, 0);
      chk("rst_rx_ready", rx_ready_o, 0);
      chk("rst_reg_done", reg_done_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_overrun", overrun_o, 0);
      chk("rst_put_ack", put_ack_o, 0);
      chk("rst_get_valid", get_valid_o, 0);
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
      chk("rx_ready_after_rst", rx_ready_o, 1);

      // Registration with looped REG_ACK one cycle after each REG transfer
      n_reg = 0; ack_pend = 1'b0; ack_idx = 4'd0;
      for (int c = 0; c < 200 && !reg_done_o; c++) begin
         rx_valid_i = 1'b0;
         if (ack_pend) begin
            rx_valid_i = 1'b1;
            rx_data_i  = {2'b10, ack_idx, 9'h000};
            ack_pend   = 1'b0;
         end
         if (tx_valid_o && tx_ready_i) begin
            f1 = tx_data_o;
            chk("reg_frame", f1, {2'b01, n_reg[3:0], 9'h000});
            ack_idx  = f1[12:9];
            ack_pend = 1'b1;
            n_reg++;
         end
         @(posedge clk_i); #1;
      end
      rx_valid_i = 1'b0;
      chk("reg_count", n_reg, 10);
      chk("reg_done", reg_done_o, 1);
      chk("reg_err", err_o, 0);

      // Table-driven put / RX / get vectors
      for (int i = 0; i < 12; i++) begin
         put_req_i = vecs[i].put_req; put_idx_i = vecs[i].put_idx; put_data_i = vecs[i].put_data;
         rx_valid_i = vecs[i].rx_valid; rx_data_i = vecs[i].rx_data;
         get_idx_i = vecs[i].get_idx; get_clr_i = vecs[i].get_clr;
         #1;
         chk($sformatf("v%0d_ack", i), put_ack_o, vecs[i].exp_ack);
         @(posedge clk_i); #1;
         chk($sformatf("v%0d_txv", i), tx_valid_o, vecs[i].exp_txv);
         if (vecs[i].exp_txv) chk($sformatf("v%0d_tx", i), tx_data_o, vecs[i].exp_tx);
         chk($sformatf("v%0d_err", i), err_o, vecs[i].exp_err);
         chk($sformatf("v%0d_gv", i), get_valid_o, vecs[i].exp_gv);
         chk($sformatf("v%0d_gd", i), get_data_o, vecs[i].exp_gd);
         chk($sformatf("v%0d_ovr", i), overrun_o, vecs[i].exp_ovr);
      end
      put_req_i = 1'b0; rx_valid_i = 1'b0; get_clr_i = 1'b0;

      // Back-pressure: frame held stable, second put waits for the transfer
      f1 = {2'b00, 4'd1, 9'h101};
      f2 = {2'b00, 4'd2, 9'h102};
      tx_ready_i = 1'b0;
      put_req_i = 1'b1; put_idx_i = 4'd1; put_data_i = 9'h101;
      #1;
      chk("bp_ack1", put_ack_o, 1);
      @(posedge clk_i); #1;
      chk("bp_txv", tx_valid_o, 1);
      chk("bp_tx1", tx_data_o, f1);
      put_idx_i = 4'd2; put_data_i = 9'h102;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("bp_hold_ack", put_ack_o, 0);
         chk("bp_hold_tx", tx_data_o, f1);
         chk("bp_hold_txv", tx_valid_o, 1);
         @(posedge clk_i); #1;
      end
      tx_ready_i = 1'b1;
      #1;
      chk("bp_ack2", put_ack_o, 1);
      @(posedge clk_i); #1;
      chk("bp_tx2", tx_data_o, f2);
      chk("bp_txv2", tx_valid_o, 1);
      put_req_i = 1'b0;
      tx_ready_i = 1'b0;
      get_idx_i = 4'd9;

      // Reset in the middle of a held transfer
      #3;
      rst_ni = 1'b0;
      #1;
      chk("mid_rst_txv", tx_valid_o, 0);
      chk("mid_rst_reg_done", reg_done_o, 0);
      chk("mid_rst_err", err_o, 0);
      chk("mid_rst_ovr", overrun_o, 0);
      chk("mid_rst_rx_ready", rx_ready_o, 0);
      chk("mid_rst_gv", get_valid_o, 0);
      chk("mid_rst_gd", get_data_o, 0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
      chk("restart_txv", tx_valid_o, 1);
      chk("restart_tx", tx_data_o, {2'b01, 4'd0, 9'h000});
      chk("restart_rx_ready", rx_ready_o, 1);

      // Put before registration completes
      put_req_i = 1'b1; put_idx_i = 4'd0; put_data_i = 9'h001;
      #1;
      chk("early_put_ack", put_ack_o, 0);
      @(posedge clk_i); #1;
      put_req_i = 1'b0;
      chk("early_put_err", err_o, 1);
      chk("early_put_tx", tx_data_o, {2'b01, 4'd0, 9'h000});
      @(posedge clk_i); #1;
      chk("early_put_err_pulse", err_o, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
